// File: rtl/stopwatch_if.sv
// Button inputs and control outputs between the stopwatch front-end and its consumers.
interface stopwatch_if;
    logic       btn_start_stop;
    logic       btn_lap_reset;
    logic [2:0] state;
    logic       tick;
    logic       clear;
    logic       freeze;

    modport master (
        output btn_start_stop,
        output btn_lap_reset,
        input  state,
        input  tick,
        input  clear,
        input  freeze
    );

    modport slave (
        input  btn_start_stop,
        input  btn_lap_reset,
        output state,
        output tick,
        output clear,
        output freeze
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end: button synchronise/debounce, start/stop/lap/clear FSM,
// and the 1 ms count-enable prescaler feeding the BCD counter.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV        = 50000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input logic        clk,
    input logic        rst_n,
    stopwatch_if.slave sw
);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int          NB = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        RUN   = 3'b001,
        STOP  = 3'b010,
        LAP   = 3'b011,
        CLEAR = 3'b100
    } state_t;

    logic [NB-1:0] raw;
    logic [NB-1:0] sync1_q;
    logic [NB-1:0] sync2_q;
    logic [NB-1:0] deb_q;
    logic [NB-1:0] deb_d_q;
    logic [NB-1:0] press;
    logic [DW-1:0] cnt_q [NB];

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_q;
    logic          tick_d;
    logic          clear_q;
    logic          clear_d;
    logic          freeze_q;
    logic          freeze_d;

    logic ss;
    logic lr;

    // bit 0 = start/stop, bit 1 = lap/reset
    assign raw = {sw.btn_lap_reset, sw.btn_start_stop};

    // Two-flop synchronisers and per-button debounce counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            deb_d_q <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            deb_d_q <= deb_q;
            for (int i = 0; i < NB; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_q[i] <= '0;
                    deb_q[i] <= sync2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + DW'(1);
                end
            end
        end
    end

    // Press = rising edge of the debounced level; releases are ignored
    assign press = deb_q & ~deb_d_q;
    assign ss    = press[0];
    assign lr    = press[1];

    // State register plus registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            clear_q  <= 1'b0;
            freeze_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            clear_q  <= clear_d;
            freeze_q <= freeze_d;
        end
    end

    // Next-state logic; start/stop has priority over lap/reset
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = ss ? RUN : IDLE;
            RUN:     state_d = ss ? STOP : (lr ? LAP : RUN);
            LAP:     state_d = ss ? STOP : (lr ? RUN : LAP);
            STOP:    state_d = ss ? RUN : (lr ? CLEAR : STOP);
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: prescaler keeps counting in LAP and holds its phase in STOP
    always_comb begin
        presc_d  = '0;
        tick_d   = 1'b0;
        clear_d  = 1'b0;
        freeze_d = 1'b0;
        case (state_q)
            RUN, LAP: begin
                if (presc_q == PW'(TICK_DIV - 1)) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            STOP:    presc_d = presc_q;
            default: presc_d = '0;
        endcase
        case (state_d)
            CLEAR:   clear_d  = 1'b1;
            LAP:     freeze_d = 1'b1;
            default: ;
        endcase
    end

    assign sw.state  = state_q;
    assign sw.tick   = tick_q;
    assign sw.clear  = clear_q;
    assign sw.freeze = freeze_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a cycle-level behavioural model.
module tb_stopwatch_ctrl;
    localparam int T = 4;
    localparam int D = 8;
    localparam int S_IDLE = 0, S_RUN = 1, S_STOP = 2, S_LAP = 3, S_CLR = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   cmp_en = 1'b0;

    stopwatch_if sw_if ();

    stopwatch_ctrl #(.TICK_DIV(T), .DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw_if)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a button level is accepted once the last D synchronised
    // samples (raw sampled two edges earlier) all disagree with the accepted level.
    int st_m, p_m;
    bit tick_m, clear_m, freeze_m;
    bit deb_m [2];
    bit debp_m [2];
    bit h_ss [$];
    bit h_lr [$];

    function automatic bit all_opposite(input bit h [$], input bit lvl);
        for (int k = 2; k <= D + 1; k++) begin
            if (h[h.size() - k] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_reset();
        st_m = S_IDLE; p_m = 0;
        tick_m = 0; clear_m = 0; freeze_m = 0;
        for (int b = 0; b < 2; b++) begin deb_m[b] = 0; debp_m[b] = 0; end
        h_ss.delete(); h_lr.delete();
        for (int k = 0; k < D + 2; k++) begin h_ss.push_back(1'b0); h_lr.push_back(1'b0); end
    endfunction

    function automatic void model_step(input bit raw_ss, input bit raw_lr);
        bit ss, lr;
        int old;
        ss = deb_m[0] && !debp_m[0];
        lr = deb_m[1] && !debp_m[1];
        debp_m[0] = deb_m[0];
        debp_m[1] = deb_m[1];
        if (all_opposite(h_ss, deb_m[0])) deb_m[0] = !deb_m[0];
        if (all_opposite(h_lr, deb_m[1])) deb_m[1] = !deb_m[1];
        h_ss.push_back(raw_ss); void'(h_ss.pop_front());
        h_lr.push_back(raw_lr); void'(h_lr.pop_front());
        old = st_m;
        case (old)
            S_IDLE: if (ss) st_m = S_RUN;
            S_RUN:  if (ss) st_m = S_STOP; else if (lr) st_m = S_LAP;
            S_LAP:  if (ss) st_m = S_STOP; else if (lr) st_m = S_RUN;
            S_STOP: if (ss) st_m = S_RUN;  else if (lr) st_m = S_CLR;
            default: st_m = S_IDLE;
        endcase
        if (old == S_RUN || old == S_LAP) begin
            tick_m = (p_m == T - 1);
            p_m = (p_m + 1) % T;
        end else if (old == S_STOP) begin
            tick_m = 0;
        end else begin
            tick_m = 0;
            p_m = 0;
        end
        clear_m  = (st_m == S_CLR);
        freeze_m = (st_m == S_LAP);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step(sw_if.btn_start_stop, sw_if.btn_lap_reset);
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_state",  32'(sw_if.state),  32'(st_m));
            check("m_tick",   32'(sw_if.tick),   32'(tick_m));
            check("m_clear",  32'(sw_if.clear),  32'(clear_m));
            check("m_freeze", 32'(sw_if.freeze), 32'(freeze_m));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press(input bit ss, input bit lr, input int exp_st, input string name);
        sw_if.btn_start_stop = ss;
        sw_if.btn_lap_reset  = lr;
        cyc(D + 3);
        check(name, 32'(sw_if.state), 32'(exp_st));
        sw_if.btn_start_stop = 1'b0;
        sw_if.btn_lap_reset  = 1'b0;
        cyc(D + 3);
    endtask

    initial begin
        int guard;
        model_reset();
        sw_if.btn_start_stop = 1'b0;
        sw_if.btn_lap_reset  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_state",  32'(sw_if.state),  0);
        check("rst_tick",   32'(sw_if.tick),   0);
        check("rst_clear",  32'(sw_if.clear),  0);
        check("rst_freeze", 32'(sw_if.freeze), 0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;

        // Bouncing start/stop: every run shorter than the debounce window
        for (int i = 0; i < 10; i++) begin
            sw_if.btn_start_stop = ((i % 2) == 0);
            cyc(3);
        end
        sw_if.btn_start_stop = 1'b0;
        cyc(12);
        check("t2_state", 32'(sw_if.state), S_IDLE);

        // Held start/stop: RUN after edge 11, tick after edge 15, 19
        sw_if.btn_start_stop = 1'b1;
        cyc(10);
        check("t1_pre",   32'(sw_if.state), S_IDLE);
        cyc(1);
        check("t1_run",   32'(sw_if.state), S_RUN);
        cyc(3);
        check("t1_notick", 32'(sw_if.tick), 0);
        cyc(1);
        check("t1_tick1", 32'(sw_if.tick), 1);
        cyc(4);
        check("t1_tick2", 32'(sw_if.tick), 1);
        cyc(1);
        sw_if.btn_start_stop = 1'b0;
        cyc(12);

        // Lap hold and back
        press(1'b0, 1'b1, S_LAP, "t3_lap");
        check("t3_freeze1", 32'(sw_if.freeze), 1);
        press(1'b0, 1'b1, S_RUN, "t3_run");
        check("t3_freeze0", 32'(sw_if.freeze), 0);

        // Stop with prescaler held at 2, then resume
        guard = 0;
        while (p_m != 3 && guard < 10) begin
            cyc(1);
            guard++;
        end
        check("t4_align", 32'(guard < 10), 1);
        press(1'b1, 1'b0, S_STOP, "t4_stop");
        cyc(50);
        sw_if.btn_start_stop = 1'b1;
        cyc(D + 3);
        check("t4_resume", 32'(sw_if.state), S_RUN);
        cyc(1);
        check("t4_notick", 32'(sw_if.tick), 0);
        cyc(1);
        check("t4_tick", 32'(sw_if.tick), 1);
        sw_if.btn_start_stop = 1'b0;
        cyc(D + 3);

        // STOP -> CLEAR -> IDLE, then simultaneous presses in RUN
        press(1'b1, 1'b0, S_STOP, "t5_stop");
        sw_if.btn_lap_reset = 1'b1;
        cyc(D + 3);
        check("t5_clr_state", 32'(sw_if.state), S_CLR);
        check("t5_clr_pulse", 32'(sw_if.clear), 1);
        cyc(1);
        check("t5_idle",      32'(sw_if.state), S_IDLE);
        check("t5_clr_low",   32'(sw_if.clear), 0);
        sw_if.btn_lap_reset = 1'b0;
        cyc(D + 3);
        press(1'b1, 1'b0, S_RUN, "t5_run");
        press(1'b1, 1'b1, S_STOP, "t5_both");
        check("t5_both_hold", 32'(sw_if.state), S_STOP);

        // Asynchronous reset mid-RUN, release with start/stop held
        press(1'b1, 1'b0, S_RUN, "t6_run");
        cyc(2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_state",  32'(sw_if.state),  0);
        check("t6_tick",   32'(sw_if.tick),   0);
        check("t6_clear",  32'(sw_if.clear),  0);
        check("t6_freeze", 32'(sw_if.freeze), 0);
        sw_if.btn_start_stop = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(10);
        check("t6_pre", 32'(sw_if.state), S_IDLE);
        cyc(1);
        check("t6_run2", 32'(sw_if.state), S_RUN);
        sw_if.btn_start_stop = 1'b0;
        cyc(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
